dir_rotate_gen: RTL



---
 rtl/dir_rotate_gen.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/dir_rotate_gen.sv
// rtl/dir_rotate_gen.sv - rotated descriptor sampling-grid offset generator
//
// Takes a 5-bit orientation bin k (angle k*11.25 deg). It then streams GRID*GRID
// rotated grid offsets (dx, dy), computed from a Q1.7 cos/sin ROM through
// a 2-stage multiply/add pipeline.
//
// Ports:
//   clk        clock
//   rst        synchronous active-high reset
//   start      begin a sweep (sampled only when idle)
//   dir        orientation bin, captured when start is accepted
//   busy       high from the accepting edge until done
//   out_valid  rotated sample available
//   out_ready  downstream accepts the sample
//   out_dx     signed rotated x offset
//   out_dy     signed rotated y offset
//   out_idx    grid index row*16+col of the sample
//   done       one-cycle pulse after the last handshake
module dir_rotate_gen #(
    parameter int GRID   = 16,
    parameter int TRIG_W = 8,
    parameter int OUT_W  = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [4:0]              dir,
    output logic                    busy,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [OUT_W-1:0] out_dx,
    output logic signed [OUT_W-1:0] out_dy,
    output logic [7:0]              out_idx,
    output logic                    done
);

    localparam int         PW   = TRIG_W + 5;   // product width (5-bit offset x trig)
    localparam int         SW   = PW + 1;       // sum width
    localparam logic [7:0] LAST = 8'(GRID * GRID - 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN} state_t;

    state_t state, state_nxt;

    // First quadrant of round(127*cos(2*pi*i/32)), i = 0..8.
    function automatic logic [TRIG_W-1:0] quarter(input logic [3:0] i);
        logic [TRIG_W-1:0] r;
        case (i)
            4'd0:    r = TRIG_W'(127);
            4'd1:    r = TRIG_W'(125);
            4'd2:    r = TRIG_W'(117);
            4'd3:    r = TRIG_W'(106);
            4'd4:    r = TRIG_W'(90);
            4'd5:    r = TRIG_W'(71);
            4'd6:    r = TRIG_W'(49);
            4'd7:    r = TRIG_W'(25);
            default: r = '0;
        endcase
        return r;
    endfunction

    // Full-circle cos built from the quarter table by quadrant symmetry.
    function automatic logic [TRIG_W-1:0] cos_rom(input logic [4:0] k);
        logic [TRIG_W-1:0] m;
        logic [3:0]        lo;
        logic [3:0]        mirror;
        lo     = {1'b0, k[2:0]};
        mirror = 4'd8 - lo;
        case (k[4:3])
            2'd0:    m = quarter(lo);
            2'd1:    m = (~quarter(mirror)) + TRIG_W'(1);
            2'd2:    m = (~quarter(lo)) + TRIG_W'(1);
            default: m = quarter(mirror);
        endcase
        return m;
    endfunction

    // sin(theta) = cos(theta - 90 deg); the 5-bit subtraction wraps the bin.
    function automatic logic [TRIG_W-1:0] sin_rom(input logic [4:0] k);
        return cos_rom(k - 5'd8);
    endfunction

    function automatic logic signed [PW-1:0] mul(input logic signed [4:0]        a,
                                                  input logic signed [TRIG_W-1:0] b);
        return PW'(a) * PW'(b);
    endfunction

    logic [4:0]               dir_q;
    logic signed [TRIG_W-1:0] cos_r, sin_r;
    logic [7:0]               idx;
    logic                     issue_en;

    logic                     s1_valid;
    logic signed [PW-1:0]     s1_uc, s1_vs, s1_us, s1_vc;
    logic [7:0]               s1_idx;

    logic                     advance;
    logic                     accept;
    logic                     load;
    logic                     last_hs;
    logic signed [4:0]        u, v;
    logic signed [SW-1:0]     sx, sy;

    // 2*col-15 == {col,1} - 16: flipping the MSB of {col,1} does the -16.
    assign u = {~idx[3], idx[2:0], 1'b1};
    assign v = {~idx[7], idx[6:4], 1'b1};

    assign sx = SW'(s1_uc) - SW'(s1_vs) + SW'(128);
    assign sy = SW'(s1_us) + SW'(s1_vc) + SW'(128);

    assign advance = !out_valid || out_ready;
    assign last_hs = out_valid && out_ready && (out_idx == LAST);

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_LOAD;
            S_LOAD:  state_nxt = S_RUN;
            S_RUN:   if (last_hs) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy   = (state != S_IDLE);
        accept = (state == S_IDLE) && start;
        load   = (state == S_LOAD);
    end

    // Datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            dir_q     <= '0;
            cos_r     <= '0;
            sin_r     <= '0;
            idx       <= '0;
            issue_en  <= 1'b0;
            s1_valid  <= 1'b0;
            s1_uc     <= '0;
            s1_vs     <= '0;
            s1_us     <= '0;
            s1_vc     <= '0;
            s1_idx    <= '0;
            out_valid <= 1'b0;
            out_dx    <= '0;
            out_dy    <= '0;
            out_idx   <= '0;
            done      <= 1'b0;
        end else begin
            if (accept) dir_q <= dir;

            // Whole pipe and the issue counter move together, or not at all.
            if (advance) begin
                s1_valid <= issue_en;
                s1_uc    <= mul(u, cos_r);
                s1_vs    <= mul(v, sin_r);
                s1_us    <= mul(u, sin_r);
                s1_vc    <= mul(v, cos_r);
                s1_idx   <= idx;
                if (issue_en) begin
                    idx <= idx + 8'd1;
                    if (idx == LAST) issue_en <= 1'b0;
                end

                out_valid <= s1_valid;
                if (s1_valid) begin
                    // Arithmetic >>> 8 of the rounded sum is just its upper bits.
                    out_dx  <= sx[8 +: OUT_W];
                    out_dy  <= sy[8 +: OUT_W];
                    out_idx <= s1_idx;
                end
            end

            if (load) begin
                cos_r    <= cos_rom(dir_q);
                sin_r    <= sin_rom(dir_q);
                idx      <= '0;
                issue_en <= 1'b1;
            end

            done <= last_hs;
        end
    end

endmodule
